// File: rtl/multi_timer.sv
// N-channel programmable timer: per-channel period and mode (off/periodic/one-shot),
// producing a one-cycle tick, a toggling level output and a busy flag, all in the clk domain.
module multi_timer #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter int unsigned RESET_MODE     = 1,
  localparam int unsigned CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN_P = 2'd1,
    ST_RUN_1 = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] RST_PERIOD    = WIDTH'(DEFAULT_PERIOD);
  localparam logic [1:0]       RST_MODE_BITS = 2'(RESET_MODE);

  logic [WIDTH-1:0] period [CHANNELS];
  logic [WIDTH-1:0] count  [CHANNELS];
  state_e           state  [CHANNELS];

  // Reserved encoding 2'b11 falls through to off.
  function automatic state_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return ST_RUN_P;
      2'b10:   return ST_RUN_1;
      default: return ST_OFF;
    endcase
  endfunction

  // Terminal count is P_eff-1 with P_eff = max(period, 1).
  function automatic logic [WIDTH-1:0] last_count(input logic [WIDTH-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        period[i] <= RST_PERIOD;
        state[i]  <= decode_mode(RST_MODE_BITS);
        count[i]  <= '0;
        tick[i]   <= 1'b0;
        level[i]  <= 1'b0;
      end else if (cfg_wr && (cfg_ch == CW'(i))) begin
        // A write outranks a coincident expiry: no tick, level untouched.
        period[i] <= cfg_period;
        state[i]  <= decode_mode(cfg_mode);
        count[i]  <= '0;
        tick[i]   <= 1'b0;
      end else if (state[i] == ST_OFF) begin
        count[i] <= '0;
        tick[i]  <= 1'b0;
      end else if (count[i] == last_count(period[i])) begin
        count[i] <= '0;
        tick[i]  <= 1'b1;
        level[i] <= ~level[i];
        if (state[i] == ST_RUN_1) begin
          state[i] <= ST_OFF;
        end
      end else begin
        count[i] <= count[i] + 1'b1;
        tick[i]  <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      busy[i] = (state[i] != ST_OFF);
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: a countdown reference model pushes expected {tick,level,busy}
// per edge into a scoreboard queue; each scenario task pops and compares after the edge.
module tb_multi_timer;

  localparam int unsigned DP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] tick, level, busy;
  logic [2:0] tick3, level3, busy3;

  always #5 clk = ~clk;

  multi_timer #(
    .CHANNELS(4), .WIDTH(8), .DEFAULT_PERIOD(DP), .RESET_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .tick(tick), .level(level), .busy(busy)
  );

  // Three channels still need a 2-bit index, so index 3 is out of range here.
  multi_timer #(
    .CHANNELS(3), .WIDTH(8), .DEFAULT_PERIOD(DP), .RESET_MODE(1)
  ) dut3 (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .tick(tick3), .level(level3), .busy(busy3)
  );

  logic [7:0]  m_per  [4];
  int          m_mode [4];
  int          m_rem  [4];
  logic [3:0]  m_tick  = '0;
  logic [3:0]  m_level = '0;
  logic [11:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic int peff(input logic [7:0] p);
    return (p == 8'd0) ? 1 : int'(p);
  endfunction

  // Model: m_rem counts edges remaining until the next tick rises.
  task automatic drive_cycle(input logic r, input logic wr, input logic [1:0] ch,
                             input logic [7:0] per, input logic [1:0] mode);
    logic [3:0] b;
    rst = r; cfg_wr = wr; cfg_ch = ch; cfg_period = per; cfg_mode = mode;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_per[i] = 8'(DP); m_mode[i] = 1; m_rem[i] = int'(DP);
        m_tick[i] = 1'b0; m_level[i] = 1'b0;
      end else if (wr && (int'(ch) == i)) begin
        m_per[i] = per;
        m_mode[i] = (mode == 2'd1 || mode == 2'd2) ? int'(mode) : 0;
        m_rem[i] = peff(per);
        m_tick[i] = 1'b0;
      end else if (m_mode[i] != 0) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_tick[i] = 1'b1;
          m_level[i] = ~m_level[i];
          m_rem[i] = peff(m_per[i]);
          if (m_mode[i] == 2) m_mode[i] = 0;
        end else begin
          m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
      b[i] = (m_mode[i] != 0);
    end
    sb.push_back({m_tick, m_level, b});
    @(posedge clk); #1;
    rst = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL reset: got %h expected %h", {tick, level, busy}, exp);
      end
    end
    vectors++;
    if ({tick, level, busy} !== 12'h00F) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", {tick, level, busy}, 12'h00F);
    end
  endtask

  task automatic test_periodic_default();
    logic [11:0] exp;
    int first = -1;
    for (int k = 1; k <= 45; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL periodic cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (first < 0 && tick[0]) first = k;
    end
    vectors++;
    if (first !== 10) begin
      miscompares++;
      $display("FAIL first_tick: got %0d expected %0d", first, 10);
    end
  endtask

  task automatic test_reprogram();
    logic [11:0] exp;
    int first1 = -1;
    int ticks2 = 0;
    drive_cycle(1'b0, 1'b1, 2'd1, 8'd3, 2'b01);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL reprog_wr1: got %h expected %h", {tick, level, busy}, exp);
    end
    drive_cycle(1'b0, 1'b1, 2'd2, 8'd0, 2'b01);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL reprog_wr2: got %h expected %h", {tick, level, busy}, exp);
    end
    for (int k = 1; k <= 30; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL reprog cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (first1 < 0 && tick[1]) first1 = k;
      if (tick[2]) ticks2++;
    end
    vectors++;
    if (first1 !== 2) begin
      miscompares++;
      $display("FAIL ch1_first_tick: got %0d expected %0d", first1, 2);
    end
    vectors++;
    if (ticks2 !== 30) begin
      miscompares++;
      $display("FAIL ch2_tick_count: got %0d expected %0d", ticks2, 30);
    end
  endtask

  task automatic test_one_shot();
    logic [11:0] exp;
    int first3 = -1;
    int ticks3 = 0;
    drive_cycle(1'b0, 1'b1, 2'd3, 8'd5, 2'b10);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL oneshot_wr: got %h expected %h", {tick, level, busy}, exp);
    end
    for (int k = 1; k <= 55; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL oneshot cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (tick[3]) begin
        ticks3++;
        if (first3 < 0) first3 = k;
      end
    end
    vectors++;
    if (ticks3 !== 1 || first3 !== 5) begin
      miscompares++;
      $display("FAIL oneshot_ticks: got count %0d at %0d expected count 1 at 5", ticks3, first3);
    end
    vectors++;
    if (busy[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_busy: got %b expected 0", busy[3]);
    end
  endtask

  task automatic test_off_reenable();
    logic [11:0] exp;
    logic lvl0;
    int ticks_off = 0;
    int first0 = -1;
    lvl0 = level[0];
    drive_cycle(1'b0, 1'b1, 2'd0, 8'd10, 2'b00);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL off_wr: got %h expected %h", {tick, level, busy}, exp);
    end
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL off cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (tick[0] || level[0] !== lvl0) ticks_off++;
    end
    vectors++;
    if (ticks_off !== 0) begin
      miscompares++;
      $display("FAIL off_hold: got %0d activity cycles expected 0", ticks_off);
    end
    drive_cycle(1'b0, 1'b1, 2'd0, 8'd4, 2'b01);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL reenable_wr: got %h expected %h", {tick, level, busy}, exp);
    end
    for (int k = 1; k <= 20; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL reenable cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (first0 < 0 && tick[0]) first0 = k;
    end
    vectors++;
    if (first0 !== 4) begin
      miscompares++;
      $display("FAIL reenable_first: got %0d expected %0d", first0, 4);
    end
  endtask

  task automatic test_write_at_expiry();
    logic [11:0] exp;
    int first1 = -1;
    for (int k = 0; k < 10 && m_rem[1] != 1; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL align cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
    end
    vectors++;
    if (m_rem[1] != 1) begin
      miscompares++;
      $display("FAIL align_timeout: got rem %0d expected 1", m_rem[1]);
    end
    drive_cycle(1'b0, 1'b1, 2'd1, 8'd3, 2'b01);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL expiry_wr: got %h expected %h", {tick, level, busy}, exp);
    end
    vectors++;
    if (tick[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL expiry_no_tick: got %b expected 0", tick[1]);
    end
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL expiry cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      if (first1 < 0 && tick[1]) first1 = k;
    end
    vectors++;
    if (first1 !== 3) begin
      miscompares++;
      $display("FAIL expiry_next_tick: got %0d expected %0d", first1, 3);
    end
  endtask

  task automatic test_bad_channel_and_reset();
    logic [11:0] exp;
    logic [8:0]  exp3;
    for (int k = 1; k <= 5; k++) begin
      drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL premid cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
    end
    drive_cycle(1'b1, 1'b0, 2'd0, 8'd0, 2'd0);
    exp = sb.pop_front(); vectors++;
    if ({tick, level, busy} !== exp) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected %h", {tick, level, busy}, exp);
    end
    vectors++;
    if ({tick3, level3, busy3} !== 9'h007) begin
      miscompares++;
      $display("FAIL mid_reset_3ch: got %h expected %h", {tick3, level3, busy3}, 9'h007);
    end
    for (int k = 0; k <= 25; k++) begin
      if (k == 0) drive_cycle(1'b0, 1'b1, 2'd3, 8'd2, 2'b01);
      else        drive_cycle(1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
      exp = sb.pop_front(); vectors++;
      if ({tick, level, busy} !== exp) begin
        miscompares++;
        $display("FAIL badch cyc %0d: got %h expected %h", k, {tick, level, busy}, exp);
      end
      exp3 = {exp[10:8], exp[6:4], exp[2:0]}; vectors++;
      if ({tick3, level3, busy3} !== exp3) begin
        miscompares++;
        $display("FAIL badch_3ch cyc %0d: got %h expected %h", k, {tick3, level3, busy3}, exp3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic_default();
    test_reprogram();
    test_one_shot();
    test_off_reenable();
    test_write_at_expiry();
    test_bad_channel_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
